bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter NumHosts, default 2, number of data-bus hosts (index 0 = core data port).
REQ-002 SHALL have parameter NumDevices, default 4, device index order RAM=0, GPIO=1, UART=2, TIMER=3.
REQ-003 SHALL have parameter TimeoutCycles, default 15, maximum wait cycles for a device response.
REQ-004 SHALL have port clk_sys_in, input, 1, clock; all state on its rising edge.
REQ-005 SHALL have port rst_sys_in, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports host_req_i (in, NumHosts), host_addr_i (in, NumHosts x 32), host_we_i (in, NumHosts), host_be_i (in, NumHosts x 4), host_wdata_i (in, NumHosts x 32): per-host request.
REQ-007 SHALL have ports host_gnt_o, host_rvalid_o, host_err_o (out, NumHosts each), host_rdata_o (out, NumHosts x 32): per-host grant/response.
REQ-008 SHALL have ports dev_req_o (out, NumDevices), dev_addr_o (out, 16, offset within device), dev_we_o (out, 1), dev_be_o (out, 4), dev_wdata_o (out, 32): shared device request bus.
REQ-009 SHALL have ports dev_rvalid_i (in, NumDevices), dev_rdata_i (in, NumDevices x 32): device responses.

Function
REQ-010 SHALL decode: RAM 0x00100000-0x0010FFFF, GPIO 0x80000000-0x80000FFF, UART 0x80001000-0x80001FFF, TIMER 0x80002000-0x80002FFF; other addresses unmapped.
REQ-011 SHALL drive dev_addr_o = host_addr[15:0] for RAM, {4'b0, host_addr[11:0]} for other devices.
REQ-012 SHALL implement FSM IDLE, WAIT_RESP, ERR_RESP; one outstanding transaction total.
REQ-013 In IDLE with >=1 host_req_i set, SHALL select a winner round-robin starting from the host after the last granted; after reset the pointer favours host 0.
REQ-014 SHALL, in the winner's selection cycle, assert host_gnt_o[winner] for exactly one cycle, combinationally with its request; losers see gnt=0 and hold requests.
REQ-015 Mapped winner: SHALL assert dev_req_o[decoded] one cycle with winner's we/be/wdata/offset, latch winner/device index, go to WAIT_RESP.
REQ-016 Unmapped winner: SHALL grant, assert no dev_req_o, go to ERR_RESP.
REQ-017 ERR_RESP: SHALL assert host_rvalid_o and host_err_o for the latched host one cycle, rdata 0, return to IDLE.
REQ-018 WAIT_RESP: on dev_rvalid_i[latched device], SHALL, same cycle, assert host_rvalid_o[latched host] with rdata = dev_rdata_i[device], err 0, return to IDLE.
REQ-019 WAIT_RESP: SHALL count cycles from 0; if count reaches TimeoutCycles without rvalid, SHALL assert rvalid+err, rdata 0, return to IDLE.
REQ-020 SHALL ignore dev_rvalid_i from non-latched devices and in IDLE/ERR_RESP (stale late responses dropped).
REQ-021 SHALL issue no grant outside IDLE; new grant earliest in the cycle after the response (minimum 2-cycle issue interval per transaction).
REQ-022 Round-robin pointer SHALL update only on grant; host with continuous requests cannot starve another (alternation when both request).
REQ-023 host_rdata_o SHALL be 0 for every host whenever its rvalid is 0.

Reset
REQ-024 On rst_sys_in low, SHALL asynchronously force IDLE, timeout counter 0, RR pointer to host 0; all gnt/rvalid/err/dev_req outputs 0, data outputs 0.
REQ-025 Reset mid-transaction SHALL abandon it without response; device responses arriving after reset release SHALL be dropped per REQ-020.

Verification
REQ-026 Host0 read 0x00100010, RAM rvalid next cycle with 0xDEADBEEF -> gnt0 cycle N, dev_req_o=0001, dev_addr_o=0x0010, host_rvalid_o[0] cycle N+1 with 0xDEADBEEF, err 0.
REQ-027 Host0 and host1 both request continuously after reset -> grants alternate 0,1,0,1; each grant follows previous response by one cycle.
REQ-028 Host1 write 0x80001004 data 0x41, be 0xF -> dev_req_o=0100, dev_addr_o=0x0004, dev_we_o=1, wdata 0x41; UART rvalid completes it.
REQ-029 Host0 read 0x40000000 -> gnt, no dev_req_o, next cycle rvalid=1, err=1, rdata 0.
REQ-030 TIMER request, device never responds -> rvalid+err after 15 WAIT_RESP cycles; TIMER rvalid arriving later is ignored.
REQ-031 Assert reset while in WAIT_RESP -> all outputs 0 immediately; after release, host1 request granted only after host0 preference, no stale response.

Source files
------------

// File: rtl/bus_arbiter.sv
// Data-bus arbiter: round-robin selection among hosts, address decode to four
// memory-mapped devices, one outstanding transaction with response timeout.
module bus_arbiter #(
  parameter int unsigned NumHosts      = 2,
  parameter int unsigned NumDevices    = 4,
  parameter int unsigned TimeoutCycles = 15
) (
  input  logic                            clk_sys_in,
  input  logic                            rst_sys_in,
  input  logic [NumHosts-1:0]             host_req_i,
  input  logic [NumHosts-1:0][31:0]       host_addr_i,
  input  logic [NumHosts-1:0]             host_we_i,
  input  logic [NumHosts-1:0][3:0]        host_be_i,
  input  logic [NumHosts-1:0][31:0]       host_wdata_i,
  output logic [NumHosts-1:0]             host_gnt_o,
  output logic [NumHosts-1:0]             host_rvalid_o,
  output logic [NumHosts-1:0]             host_err_o,
  output logic [NumHosts-1:0][31:0]       host_rdata_o,
  output logic [NumDevices-1:0]           dev_req_o,
  output logic [15:0]                     dev_addr_o,
  output logic                            dev_we_o,
  output logic [3:0]                      dev_be_o,
  output logic [31:0]                     dev_wdata_o,
  input  logic [NumDevices-1:0]           dev_rvalid_i,
  input  logic [NumDevices-1:0][31:0]     dev_rdata_i
);

  localparam int unsigned HostW = (NumHosts > 1) ? $clog2(NumHosts) : 1;
  localparam int unsigned DevW  = (NumDevices > 1) ? $clog2(NumDevices) : 1;
  localparam int unsigned CntW  = $clog2(TimeoutCycles + 1);

  typedef enum logic [1:0] {StIdle, StWaitResp, StErrResp} state_e;

  state_e            state_q, state_d;
  logic [HostW-1:0]  host_q, host_d;
  logic [DevW-1:0]   dev_q, dev_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [HostW-1:0]  ptr_q, ptr_d;

  logic              win_found;
  logic [HostW-1:0]  win_idx;
  logic [HostW-1:0]  cand;
  logic [31:0]       win_addr;
  logic              dec_hit;
  logic [DevW-1:0]   dec_idx;
  logic [15:0]       dec_off;

  // Round-robin search: first requesting host at or after the pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NumHosts; k++) begin
      cand = HostW'((32'(ptr_q) + k) % NumHosts);
      if (!win_found && host_req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Address decode of the winning host's request.
  always_comb begin
    win_addr = host_addr_i[win_idx];
    dec_hit  = 1'b1;
    dec_idx  = '0;
    dec_off  = {4'b0, win_addr[11:0]};
    if (win_addr[31:16] == 16'h0010) begin
      dec_idx = DevW'(0);
      dec_off = win_addr[15:0];
    end else if (win_addr[31:12] == 20'h80000) begin
      dec_idx = DevW'(1);
    end else if (win_addr[31:12] == 20'h80001) begin
      dec_idx = DevW'(2);
    end else if (win_addr[31:12] == 20'h80002) begin
      dec_idx = DevW'(3);
    end else begin
      dec_hit = 1'b0;
    end
  end

  // FSM next state and Mealy outputs; all outputs forced low while in reset.
  always_comb begin
    state_d       = state_q;
    host_d        = host_q;
    dev_d         = dev_q;
    cnt_d         = cnt_q;
    ptr_d         = ptr_q;
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    host_err_o    = '0;
    host_rdata_o  = '0;
    dev_req_o     = '0;
    dev_addr_o    = '0;
    dev_we_o      = 1'b0;
    dev_be_o      = '0;
    dev_wdata_o   = '0;

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          host_gnt_o[win_idx] = 1'b1;
          host_d              = win_idx;
          ptr_d               = (32'(win_idx) == NumHosts - 1) ? '0 : win_idx + 1'b1;
          if (dec_hit) begin
            dev_req_o[dec_idx] = 1'b1;
            dev_addr_o         = dec_off;
            dev_we_o           = host_we_i[win_idx];
            dev_be_o           = host_be_i[win_idx];
            dev_wdata_o        = host_wdata_i[win_idx];
            dev_d              = dec_idx;
            cnt_d              = '0;
            state_d            = StWaitResp;
          end else begin
            state_d = StErrResp;
          end
        end
      end
      StWaitResp: begin
        if (dev_rvalid_i[dev_q]) begin
          host_rvalid_o[host_q] = 1'b1;
          host_rdata_o[host_q]  = dev_rdata_i[dev_q];
          state_d               = StIdle;
        end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
          // Counter would reach TimeoutCycles this cycle: give up on the device.
          host_rvalid_o[host_q] = 1'b1;
          host_err_o[host_q]    = 1'b1;
          state_d               = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StErrResp: begin
        host_rvalid_o[host_q] = 1'b1;
        host_err_o[host_q]    = 1'b1;
        state_d               = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (!rst_sys_in) begin
      host_gnt_o    = '0;
      host_rvalid_o = '0;
      host_err_o    = '0;
      host_rdata_o  = '0;
      dev_req_o     = '0;
      dev_addr_o    = '0;
      dev_we_o      = 1'b0;
      dev_be_o      = '0;
      dev_wdata_o   = '0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_sys_in or negedge rst_sys_in) begin
    if (!rst_sys_in) begin
      state_q <= StIdle;
      host_q  <= '0;
      dev_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      host_q  <= host_d;
      dev_q   <= dev_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: transaction-level model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_bus_arbiter;
  localparam int NH = 2;
  localparam int ND = 4;
  localparam int TO = 15;

  logic                clk_sys_in = 1'b0;
  logic                rst_sys_in = 1'b0;
  logic [NH-1:0]       host_req_i = '0;
  logic [NH-1:0][31:0] host_addr_i = '0;
  logic [NH-1:0]       host_we_i = '0;
  logic [NH-1:0][3:0]  host_be_i = '0;
  logic [NH-1:0][31:0] host_wdata_i = '0;
  logic [NH-1:0]       host_gnt_o, host_rvalid_o, host_err_o;
  logic [NH-1:0][31:0] host_rdata_o;
  logic [ND-1:0]       dev_req_o;
  logic [15:0]         dev_addr_o;
  logic                dev_we_o;
  logic [3:0]          dev_be_o;
  logic [31:0]         dev_wdata_o;
  logic [ND-1:0]       dev_rvalid_i = '0;
  logic [ND-1:0][31:0] dev_rdata_i = '0;

  bus_arbiter #(.NumHosts(NH), .NumDevices(ND), .TimeoutCycles(TO)) dut (
    .clk_sys_in   (clk_sys_in),
    .rst_sys_in   (rst_sys_in),
    .host_req_i   (host_req_i),
    .host_addr_i  (host_addr_i),
    .host_we_i    (host_we_i),
    .host_be_i    (host_be_i),
    .host_wdata_i (host_wdata_i),
    .host_gnt_o   (host_gnt_o),
    .host_rvalid_o(host_rvalid_o),
    .host_err_o   (host_err_o),
    .host_rdata_o (host_rdata_o),
    .dev_req_o    (dev_req_o),
    .dev_addr_o   (dev_addr_o),
    .dev_we_o     (dev_we_o),
    .dev_be_o     (dev_be_o),
    .dev_wdata_o  (dev_wdata_o),
    .dev_rvalid_i (dev_rvalid_i),
    .dev_rdata_i  (dev_rdata_i)
  );

  always #5 clk_sys_in = ~clk_sys_in;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk_sys_in) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- host and device agents ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  req_t        q0[$];
  req_t        q1[$];
  int          hd[NH];
  int          resp_lat[ND];
  logic [31:0] resp_data[ND];

  task automatic push(input int h, input logic [31:0] a, input logic we,
                      input logic [3:0] be, input logic [31:0] wd);
    req_t r;
    r.addr = a; r.we = we; r.be = be; r.wdata = wd;
    if (h == 0) q0.push_back(r);
    else q1.push_back(r);
  endtask

  // Hosts hold a request until granted; devices answer after resp_lat cycles (0 = never).
  initial begin
    int          rv_cnt[ND];
    logic [NH-1:0] seen;
    req_t        r;
    for (int d = 0; d < ND; d++) rv_cnt[d] = 0;
    for (int h = 0; h < NH; h++) hd[h] = 0;
    forever begin
      @(negedge clk_sys_in);
      for (int d = 0; d < ND; d++) if (dev_req_o[d]) rv_cnt[d] = resp_lat[d];
      seen = host_gnt_o;
      @(posedge clk_sys_in);
      #1;
      for (int d = 0; d < ND; d++) begin
        dev_rvalid_i[d] = (rv_cnt[d] == 1);
        dev_rdata_i[d]  = (rv_cnt[d] == 1) ? resp_data[d] : 32'h0BAD_0BAD;
        if (rv_cnt[d] > 0) rv_cnt[d]--;
      end
      for (int h = 0; h < NH; h++) begin
        if (seen[h]) hd[h]++;
        if ((h == 0 && hd[0] < q0.size()) || (h == 1 && hd[1] < q1.size())) begin
          r = (h == 0) ? q0[hd[0]] : q1[hd[1]];
          host_req_i[h]   = 1'b1;
          host_addr_i[h]  = r.addr;
          host_we_i[h]    = r.we;
          host_be_i[h]    = r.be;
          host_wdata_i[h] = r.wdata;
        end else begin
          host_req_i[h] = 1'b0;
        end
      end
    end
  end

  // ---------------- transaction-level model ----------------
  function automatic bit m_decode(input logic [31:0] a, output int dev, output logic [15:0] off);
    logic [31:0] base[ND];
    logic [31:0] size[ND];
    base = '{32'h0010_0000, 32'h8000_0000, 32'h8000_1000, 32'h8000_2000};
    size = '{32'h0001_0000, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000};
    dev = 0;
    off = '0;
    for (int d = 0; d < ND; d++) begin
      if (a >= base[d] && a - base[d] < size[d]) begin
        dev = d;
        off = 16'(a - base[d]);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  int          gnt_host[$];
  int          gnt_cyc[$];
  int          rsp_host[$];
  int          rsp_cyc[$];
  logic [31:0] rsp_data[$];
  logic        rsp_err[$];

  bit m_busy = 0;
  int m_last = NH - 1;
  int m_host, m_dev, m_t0;
  bit m_mapped;

  // Predict every output for the current cycle, compare, then advance the model.
  always @(negedge clk_sys_in) begin
    logic [NH-1:0]       e_gnt, e_rv, e_err;
    logic [NH-1:0][31:0] e_rd;
    logic [ND-1:0]       e_dreq;
    logic [15:0]         e_addr, off;
    logic                e_we, found, mapped;
    logic [3:0]          e_be;
    logic [31:0]         e_wd;
    int                  w, dv;
    e_gnt = '0; e_rv = '0; e_err = '0; e_rd = '0; e_dreq = '0;
    e_addr = '0; e_we = 1'b0; e_be = '0; e_wd = '0; found = 1'b0; w = 0; dv = 0;
    if (!rst_sys_in) begin
      m_busy = 0;
      m_last = NH - 1;
      chk("rst_dev_addr", 64'(dev_addr_o), 64'h0);
      chk("rst_dev_wdata", 64'(dev_wdata_o), 64'h0);
    end else if (!m_busy) begin
      for (int k = 1; k <= NH; k++) begin
        if (!found && host_req_i[(m_last + k) % NH]) begin
          found = 1'b1;
          w = (m_last + k) % NH;
        end
      end
      if (found) begin
        e_gnt[w] = 1'b1;
        mapped = m_decode(host_addr_i[w], dv, off);
        if (mapped) begin
          e_dreq[dv] = 1'b1;
          e_addr = off; e_we = host_we_i[w]; e_be = host_be_i[w]; e_wd = host_wdata_i[w];
        end
        m_busy = 1; m_host = w; m_mapped = mapped; m_dev = dv; m_t0 = cyc; m_last = w;
      end
    end else begin
      if (!m_mapped) begin
        e_rv[m_host] = 1'b1; e_err[m_host] = 1'b1; m_busy = 0;
      end else if (dev_rvalid_i[m_dev]) begin
        e_rv[m_host] = 1'b1; e_rd[m_host] = dev_rdata_i[m_dev]; m_busy = 0;
      end else if (cyc - m_t0 >= TO) begin
        e_rv[m_host] = 1'b1; e_err[m_host] = 1'b1; m_busy = 0;
      end
    end
    chk("gnt", 64'(host_gnt_o), 64'(e_gnt));
    chk("dev_req", 64'(dev_req_o), 64'(e_dreq));
    chk("rvalid", 64'(host_rvalid_o), 64'(e_rv));
    chk("err", 64'(host_err_o), 64'(e_err));
    chk("rdata", 64'(host_rdata_o), 64'(e_rd));
    if (e_dreq != '0) begin
      chk("dev_addr", 64'(dev_addr_o), 64'(e_addr));
      chk("dev_we", 64'(dev_we_o), 64'(e_we));
      chk("dev_be", 64'(dev_be_o), 64'(e_be));
      chk("dev_wdata", 64'(dev_wdata_o), 64'(e_wd));
    end
    for (int h = 0; h < NH; h++) begin
      if (host_gnt_o[h]) begin gnt_host.push_back(h); gnt_cyc.push_back(cyc); end
      if (host_rvalid_o[h]) begin
        rsp_host.push_back(h); rsp_cyc.push_back(cyc);
        rsp_data.push_back(host_rdata_o[h]); rsp_err.push_back(host_err_o[h]);
      end
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic wait_gnt(input int max);
    int i = 0;
    do begin @(negedge clk_sys_in); i++; end while (host_gnt_o == '0 && i < max);
    chk("gnt_within_bound", 64'(host_gnt_o != '0), 64'h1);
  endtask

  task automatic wait_rsp(input int max);
    int i = 0;
    do begin @(negedge clk_sys_in); i++; end while (host_rvalid_o == '0 && i < max);
    chk("rsp_within_bound", 64'(host_rvalid_o != '0), 64'h1);
  endtask

  task automatic wait_gnt_count(input int n, input int max);
    int i = 0;
    while (gnt_host.size() < n && i < max) begin @(negedge clk_sys_in); i++; end
    @(negedge clk_sys_in);
    chk("grant_count", 64'(gnt_host.size() >= n), 64'h1);
  endtask

  task automatic apply_reset();
    @(posedge clk_sys_in); #1 rst_sys_in = 1'b0;
    #1;
    chk("rst_now_gnt", 64'(host_gnt_o), 64'h0);
    chk("rst_now_devreq", 64'(dev_req_o), 64'h0);
    chk("rst_now_rvalid", 64'(host_rvalid_o), 64'h0);
    repeat (2) @(posedge clk_sys_in);
    #1 rst_sys_in = 1'b1;
  endtask

  initial begin
    int b, rb, g;
    resp_lat  = '{1, 1, 1, 1};
    resp_data = '{32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_0055, 32'h2222_2222};
    repeat (3) @(posedge clk_sys_in);
    #1 rst_sys_in = 1'b1;
    repeat (2) @(negedge clk_sys_in);

    // RAM read from host 0, one-cycle device latency.
    push(0, 32'h0010_0010, 1'b0, 4'hF, 32'h0);
    wait_gnt(10);
    chk("t1_gnt", 64'(host_gnt_o), 64'h1);
    chk("t1_dev_req", 64'(dev_req_o), 64'h1);
    chk("t1_dev_addr", 64'(dev_addr_o), 64'h0010);
    @(negedge clk_sys_in);
    chk("t1_rvalid", 64'(host_rvalid_o), 64'h1);
    chk("t1_rdata", 64'(host_rdata_o[0]), 64'hDEAD_BEEF);
    chk("t1_err", 64'(host_err_o), 64'h0);
    repeat (2) @(negedge clk_sys_in);

    // UART write from host 1.
    push(1, 32'h8000_1004, 1'b1, 4'hF, 32'h41);
    wait_gnt(10);
    chk("t2_gnt", 64'(host_gnt_o), 64'h2);
    chk("t2_dev_req", 64'(dev_req_o), 64'h4);
    chk("t2_dev_addr", 64'(dev_addr_o), 64'h0004);
    chk("t2_we", 64'(dev_we_o), 64'h1);
    chk("t2_wdata", 64'(dev_wdata_o), 64'h41);
    @(negedge clk_sys_in);
    chk("t2_rvalid", 64'(host_rvalid_o), 64'h2);
    chk("t2_rdata", 64'(host_rdata_o[1]), 64'h55);
    repeat (2) @(negedge clk_sys_in);

    // Unmapped address: grant, no device request, error response next cycle.
    push(0, 32'h4000_0000, 1'b0, 4'hF, 32'h0);
    wait_gnt(10);
    chk("t3_gnt", 64'(host_gnt_o), 64'h1);
    chk("t3_dev_req", 64'(dev_req_o), 64'h0);
    @(negedge clk_sys_in);
    chk("t3_rvalid", 64'(host_rvalid_o), 64'h1);
    chk("t3_err", 64'(host_err_o), 64'h1);
    chk("t3_rdata", 64'(host_rdata_o), 64'h0);

    // Both hosts request continuously after reset: strict alternation from host 0.
    apply_reset();
    b = gnt_host.size();
    rb = rsp_host.size();
    for (int i = 0; i < 4; i++) begin
      push(0, 32'h0010_0100 + 32'(i * 4), 1'b0, 4'hF, 32'h0);
      push(1, 32'h0010_0200 + 32'(i * 4), 1'b0, 4'hF, 32'h0);
    end
    wait_gnt_count(b + 8, 40);
    for (int i = 0; i < 4; i++) chk("t4_alt_host", 64'(gnt_host[b + i]), 64'(i % 2));
    for (int i = 1; i < 4; i++) chk("t4_gnt_gap", 64'(gnt_cyc[b + i] - gnt_cyc[b + i - 1]), 64'd2);
    chk("t4_rsp_lag", 64'(rsp_cyc[rb] - gnt_cyc[b]), 64'd1);
    chk("t4_next_gnt_lag", 64'(gnt_cyc[b + 1] - rsp_cyc[rb]), 64'd1);
    repeat (3) @(negedge clk_sys_in);

    // TIMER never answers in time: error after TO wait cycles, late rvalid dropped.
    resp_lat[3] = 20;
    push(0, 32'h8000_2008, 1'b0, 4'hF, 32'h0);
    wait_gnt(10);
    chk("t5_dev_req", 64'(dev_req_o), 64'h8);
    chk("t5_dev_addr", 64'(dev_addr_o), 64'h0008);
    g = cyc;
    wait_rsp(30);
    chk("t5_timeout_lat", 64'(cyc - g), 64'd15);
    chk("t5_err", 64'(host_err_o), 64'h1);
    chk("t5_rdata", 64'(host_rdata_o), 64'h0);
    @(negedge clk_sys_in);
    rb = rsp_host.size();
    repeat (9) @(negedge clk_sys_in);
    chk("t5_late_ignored", 64'(rsp_host.size()), 64'(rb));

    // Reset while waiting on RAM; stale RAM rvalid must not complete later work.
    resp_lat[0] = 3;
    push(0, 32'h0010_0040, 1'b0, 4'hF, 32'h0);
    wait_gnt(10);
    @(posedge clk_sys_in); #1 rst_sys_in = 1'b0;
    push(0, 32'h8000_0010, 1'b0, 4'hF, 32'h0);
    push(1, 32'h8000_0020, 1'b0, 4'hF, 32'h0);
    #1;
    chk("t6_rst_gnt", 64'(host_gnt_o), 64'h0);
    chk("t6_rst_rvalid", 64'(host_rvalid_o), 64'h0);
    chk("t6_rst_devreq", 64'(dev_req_o), 64'h0);
    chk("t6_rst_rdata", 64'(host_rdata_o), 64'h0);
    b = gnt_host.size();
    rb = rsp_host.size();
    @(posedge clk_sys_in); #1 rst_sys_in = 1'b1;
    wait_gnt_count(b + 2, 20);
    chk("t6_first_host", 64'(gnt_host[b]), 64'h0);
    chk("t6_second_host", 64'(gnt_host[b + 1]), 64'h1);
    chk("t6_rsp_host", 64'(rsp_host[rb]), 64'h0);
    chk("t6_rsp_data", 64'(rsp_data[rb]), 64'h1111_1111);
    chk("t6_rsp_err", 64'(rsp_err[rb]), 64'h0);
    chk("t6_rsp_lag", 64'(rsp_cyc[rb] - gnt_cyc[b]), 64'd1);
    repeat (4) @(negedge clk_sys_in);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", n_checks,
             n_errors);
    $fatal(1);
  end

endmodule
